// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the CPU fetch path:
// FSM state encoding, instruction word width and inst_mem byte-address width.
package inst_loader_pkg;

  localparam int INST_W      = 32;
  localparam int IMEM_ADDR_W = 8;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_CHK   = 3'd4,
    S_FIN   = 3'd5
  } state_e;

endpackage

// File: rtl/inst_loader_if.sv
// Loader-facing bundle: host byte stream, load control/status and the inst_mem write port.
// master = host/memory side, slave = the loader itself.
interface inst_loader_if #(
  parameter int ADDR_W = inst_loader_pkg::IMEM_ADDR_W
) ();

  logic                              start;
  logic [7:0]                        byte_in;
  logic                              byte_valid;
  logic                              byte_ready;
  logic                              mem_we;
  logic [ADDR_W-1:0]                 mem_addr;
  logic [inst_loader_pkg::INST_W-1:0] mem_data;
  logic                              cpu_hold;
  logic                              busy;
  logic                              done;
  logic                              err;

  modport master (
    output start, byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, err
  );

  modport slave (
    input  start, byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_data, cpu_hold, busy, done, err
  );

endinterface

// File: rtl/inst_loader_timeout.sv
// loader_timeout: clearable idle-cycle counter that saturates at LIMIT and
// flags the terminal count until cleared.
module inst_loader_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_en,
  input  logic i_clr,
  output logic o_expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] r_cnt;

  assign o_expired = (r_cnt == CNT_W'(LIMIT));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_expired) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Byte-stream program loader: header N, then 4N little-endian bytes written as words
// into inst_mem while the CPU is held in reset. Optional trailing XOR checksum byte
// when INST_LOADER_CHECKSUM_EN is defined.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int ADDR_W      = IMEM_ADDR_W,
  parameter int MAX_WORDS   = 64,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  inst_loader_if.slave io_bus
);

  // word count needs one more bit than the word index so that N == MAX_WORDS fits
  localparam int CNT_W = ADDR_W - 1;
  localparam int IDX_W = ADDR_W - 2;

  state_e            r_state;
  logic              r_byte_ready;
  logic              r_mem_we;
  logic              r_cpu_hold;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [INST_W-1:0] r_mem_data;
  logic [CNT_W-1:0]  r_n;
  logic [IDX_W-1:0]  r_word_idx;
  logic [1:0]        r_byte_idx;
`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  logic              w_hs;
  logic              w_to_active;
  logic              w_expired;
  logic              w_hdr_zero;
  logic              w_hdr_big;
  logic [CNT_W-1:0]  w_word_inc;
  logic              w_last_word;

  assign w_hs        = io_bus.byte_valid && r_byte_ready;
  assign w_to_active = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CHK);
  assign w_hdr_zero  = (io_bus.byte_in == 8'd0);
  assign w_hdr_big   = (32'(io_bus.byte_in) > 32'(MAX_WORDS));
  assign w_word_inc  = CNT_W'(r_word_idx) + CNT_W'(1);
  assign w_last_word = (w_word_inc == r_n);

  inst_loader_timeout #(
    .LIMIT (TIMEOUT_CYC)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_en      (w_to_active && !w_hs),
    .i_clr     (!w_to_active || w_hs),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_byte_ready <= 1'b0;
      r_mem_we     <= 1'b0;
      r_cpu_hold   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_data   <= '0;
      r_n          <= '0;
      r_word_idx   <= '0;
      r_byte_idx   <= '0;
`ifdef INST_LOADER_CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (io_bus.start) begin
            r_state      <= S_HDR;
            r_err        <= 1'b0;
            r_cpu_hold   <= 1'b1;
            r_busy       <= 1'b1;
            r_byte_ready <= 1'b1;
          end
        end

        S_HDR: begin
          if (w_expired) begin
            r_err        <= 1'b1;
            r_state      <= S_FIN;
            r_done       <= 1'b1;
            r_byte_ready <= 1'b0;
          end else if (w_hs) begin
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum <= io_bus.byte_in;
`endif
            if (w_hdr_zero || w_hdr_big) begin
              r_err        <= w_hdr_big;
              r_state      <= S_FIN;
              r_done       <= 1'b1;
              r_byte_ready <= 1'b0;
            end else begin
              r_n        <= CNT_W'(io_bus.byte_in);
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_state    <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (w_expired) begin
            // partial word is dropped: nothing is written
            r_err        <= 1'b1;
            r_state      <= S_FIN;
            r_done       <= 1'b1;
            r_byte_ready <= 1'b0;
          end else if (w_hs) begin
            r_mem_data[8*r_byte_idx +: 8] <= io_bus.byte_in;
            r_byte_idx                    <= r_byte_idx + 2'd1;
`ifdef INST_LOADER_CHECKSUM_EN
            r_csum <= r_csum ^ io_bus.byte_in;
`endif
            if (r_byte_idx == 2'd3) begin
              r_state      <= S_WRITE;
              r_byte_ready <= 1'b0;
              r_mem_we     <= 1'b1;
              r_mem_addr   <= {r_word_idx, 2'b00};
            end
          end
        end

        S_WRITE: begin
          r_word_idx <= w_word_inc[IDX_W-1:0];
          if (w_last_word) begin
`ifdef INST_LOADER_CHECKSUM_EN
            r_state      <= S_CHK;
            r_byte_ready <= 1'b1;
`else
            r_state      <= S_FIN;
            r_done       <= 1'b1;
`endif
          end else begin
            r_state      <= S_DATA;
            r_byte_ready <= 1'b1;
          end
        end

        S_CHK: begin
`ifdef INST_LOADER_CHECKSUM_EN
          if (w_expired) begin
            r_err        <= 1'b1;
            r_state      <= S_FIN;
            r_done       <= 1'b1;
            r_byte_ready <= 1'b0;
          end else if (w_hs) begin
            if (io_bus.byte_in != r_csum) begin
              r_err <= 1'b1;
            end
            r_state      <= S_FIN;
            r_done       <= 1'b1;
            r_byte_ready <= 1'b0;
          end
`else
          // unreachable without the checksum stage; fall through to a clean finish
          r_state      <= S_FIN;
          r_done       <= 1'b1;
          r_byte_ready <= 1'b0;
`endif
        end

        S_FIN: begin
          r_state      <= S_IDLE;
          r_cpu_hold   <= 1'b0;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
        end

        default: begin
          r_state      <= S_IDLE;
          r_cpu_hold   <= 1'b0;
          r_busy       <= 1'b0;
          r_byte_ready <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.byte_ready = r_byte_ready;
  assign io_bus.mem_we     = r_mem_we;
  assign io_bus.mem_addr   = r_mem_addr;
  assign io_bus.mem_data   = r_mem_data;
  assign io_bus.cpu_hold   = r_cpu_hold;
  assign io_bus.busy       = r_busy;
  assign io_bus.done       = r_done;
  assign io_bus.err        = r_err;

endmodule

// File: tb/tb_inst_loader.sv
// Directed bench for inst_loader: normal loads, gaps, header limits, timeout,
// mid-load reset and (with INST_LOADER_CHECKSUM_EN) checksum pass/fail.
module tb_inst_loader;
  import inst_loader_pkg::*;

  localparam int ADDR_W      = 8;
  localparam int MAX_WORDS   = 64;
  localparam int TIMEOUT_CYC = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  inst_loader_if #(.ADDR_W(ADDR_W)) bus ();

  inst_loader #(
    .ADDR_W      (ADDR_W),
    .MAX_WORDS   (MAX_WORDS),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  int done_cnt = 0;
  int lo_rdy   = 0;
  int hold_bad = 0;
  int fin_bad  = 0;
  logic [ADDR_W-1:0] wr_addr [$];
  logic [INST_W-1:0] wr_data [$];

  int done_base, wr_base, lo_base, hold_base, fin_base;
  logic [7:0]        xor_acc;
  logic [INST_W-1:0] exp_words [0:63];

  // Passive monitor: one line per memory write, plus counters for pulses and holds.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
      $display("write addr=0x%02h data=0x%08h", bus.mem_addr, bus.mem_data);
    end
    if (bus.done) begin
      done_cnt <= done_cnt + 1;
      if (!bus.cpu_hold) fin_bad <= fin_bad + 1;
    end
    if (bus.busy && !bus.byte_ready && !bus.done) lo_rdy <= lo_rdy + 1;
    if (bus.busy !== bus.cpu_hold) hold_bad <= hold_bad + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    while (!bus.byte_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", 32'(t < 20), 32'h1);
    @(posedge clk);
    #1;
    bus.byte_valid = 1'b0;
    xor_acc        = xor_acc ^ b;
  endtask

  task automatic start_load(input string tag);
    @(negedge clk);
    bus.start = 1'b1;
    xor_acc   = 8'h00;
    done_base = done_cnt;
    wr_base   = wr_addr.size();
    lo_base   = lo_rdy;
    hold_base = hold_bad;
    fin_base  = fin_bad;
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_start_busy"}, 32'(bus.busy), 32'h1);
    check({tag, "_start_hold"}, 32'(bus.cpu_hold), 32'h1);
    check({tag, "_start_rdy"}, 32'(bus.byte_ready), 32'h1);
    check({tag, "_start_err"}, 32'(bus.err), 32'h0);
  endtask

  task automatic finish_load(input string tag);
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(xor_acc, 0);
`else
    @(posedge clk);
    #1;
`endif
    check({tag, "_done_latency"}, 32'(bus.done), 32'h1);
    wait_cycles(3);
  endtask

  task automatic load_words(input string tag, input int n, input int gap);
    start_load(tag);
    send_byte(8'(n), gap);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) send_byte(exp_words[w][8*b +: 8], gap);
      check({tag, "_we"}, 32'(bus.mem_we), 32'h1);
      check({tag, "_addr"}, 32'(bus.mem_addr), 32'(w * 4));
      check({tag, "_data"}, bus.mem_data, exp_words[w]);
    end
    finish_load(tag);
  endtask

  task automatic post_check(input string tag, input int n_wr, input logic err_exp, input int lo_exp);
    check({tag, "_n_writes"}, 32'(wr_addr.size() - wr_base), 32'(n_wr));
    check({tag, "_n_done"}, 32'(done_cnt - done_base), 32'h1);
    check({tag, "_err"}, 32'(bus.err), 32'(err_exp));
    check({tag, "_rdy_low"}, 32'(lo_rdy - lo_base), 32'(lo_exp));
    check({tag, "_hold_track"}, 32'(hold_bad - hold_base), 32'h0);
    check({tag, "_hold_in_fin"}, 32'(fin_bad - fin_base), 32'h0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    bus.start      = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;
    xor_acc        = 8'h00;
    for (int i = 0; i < 64; i++) exp_words[i] = '0;

    // reset state
    wait_cycles(3);
    check("rst_rdy", 32'(bus.byte_ready), 32'h0);
    check("rst_we", 32'(bus.mem_we), 32'h0);
    check("rst_hold", 32'(bus.cpu_hold), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    check("rst_err", 32'(bus.err), 32'h0);
    check("rst_addr", 32'(bus.mem_addr), 32'h0);
    check("rst_data", bus.mem_data, 32'h0);
    rst_n = 1'b1;
    wait_cycles(2);

    // valid held in IDLE is not consumed
    bus.byte_in    = 8'h5A;
    bus.byte_valid = 1'b1;
    wait_cycles(3);
    check("idle_valid_rdy", 32'(bus.byte_ready), 32'h0);
    check("idle_valid_busy", 32'(bus.busy), 32'h0);
    bus.byte_valid = 1'b0;

    // two words, continuous valid
    exp_words[0] = 32'h12345678;
    exp_words[1] = 32'hDEADBEEF;
    load_words("two", 2, 0);
    post_check("two", 2, 1'b0, 2);
    check("two_w0_addr", 32'(wr_addr[wr_base]), 32'h00);
    check("two_w0_data", wr_data[wr_base], 32'h12345678);
    check("two_w1_addr", 32'(wr_addr[wr_base+1]), 32'h04);
    check("two_w1_data", wr_data[wr_base+1], 32'hDEADBEEF);

    // same stream with 3-cycle gaps between bytes
    load_words("gap", 2, 3);
    post_check("gap", 2, 1'b0, 2);

    // header 0: no writes, immediate finish
    start_load("hdr0");
    send_byte(8'h00, 0);
    check("hdr0_done_latency", 32'(bus.done), 32'h1);
    wait_cycles(3);
    post_check("hdr0", 0, 1'b0, 0);

    // header above capacity
    start_load("hdr41");
    send_byte(8'h41, 0);
    check("hdr41_done_latency", 32'(bus.done), 32'h1);
    wait_cycles(3);
    post_check("hdr41", 0, 1'b1, 0);

    // timeout with a partial word pending (start also clears the sticky error)
    start_load("tmo");
    send_byte(8'h01, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    t = 0;
    while (!bus.done && t < 1200) begin
      @(negedge clk);
      t++;
    end
    check("tmo_cycles", 32'(t), 32'd1026);
    wait_cycles(3);
    post_check("tmo", 0, 1'b1, 0);

    // full capacity: 64 words, last address 0xFC
    for (int i = 0; i < 64; i++)
      exp_words[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)} ^ 32'hA5C3_0000;
    load_words("max", 64, 0);
    post_check("max", 64, 1'b0, 64);
    check("max_last_addr", 32'(wr_addr[wr_base+63]), 32'hFC);

    // reset after 5 data bytes
    exp_words[0] = 32'h12345678;
    exp_words[1] = 32'hDEADBEEF;
    start_load("mrst");
    send_byte(8'h02, 0);
    for (int b = 0; b < 4; b++) send_byte(exp_words[0][8*b +: 8], 0);
    send_byte(8'hEF, 0);
    rst_n = 1'b0;
    #1;
    check("mrst_rdy", 32'(bus.byte_ready), 32'h0);
    check("mrst_we", 32'(bus.mem_we), 32'h0);
    check("mrst_hold", 32'(bus.cpu_hold), 32'h0);
    check("mrst_busy", 32'(bus.busy), 32'h0);
    check("mrst_done", 32'(bus.done), 32'h0);
    check("mrst_err", 32'(bus.err), 32'h0);
    check("mrst_addr", 32'(bus.mem_addr), 32'h0);
    check("mrst_data", bus.mem_data, 32'h0);
    check("mrst_first_word_kept", 32'(wr_addr.size() - wr_base), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles(3);
    check("mrst_idle_busy", 32'(bus.busy), 32'h0);
    check("mrst_idle_rdy", 32'(bus.byte_ready), 32'h0);
    load_words("after_rst", 2, 0);
    post_check("after_rst", 2, 1'b0, 2);

`ifdef INST_LOADER_CHECKSUM_EN
    // checksum 01^01^02^03^04 = 05
    exp_words[0] = 32'h04030201;
    start_load("csum_ok");
    send_byte(8'h01, 0);
    for (int b = 0; b < 4; b++) send_byte(exp_words[0][8*b +: 8], 0);
    send_byte(8'h05, 0);
    check("csum_ok_done_latency", 32'(bus.done), 32'h1);
    wait_cycles(3);
    post_check("csum_ok", 1, 1'b0, 1);

    start_load("csum_bad");
    send_byte(8'h01, 0);
    for (int b = 0; b < 4; b++) send_byte(exp_words[0][8*b +: 8], 0);
    send_byte(8'h06, 0);
    check("csum_bad_done_latency", 32'(bus.done), 32'h1);
    wait_cycles(3);
    post_check("csum_bad", 1, 1'b1, 1);
    check("csum_bad_addr", 32'(wr_addr[wr_base]), 32'h00);
    check("csum_bad_data", wr_data[wr_base], 32'h04030201);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
